// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle shared by the CPU/DMA requesters, the memory bus arbiter and the bus bridge.
// The master modport is the arbiter's view; slave is the view of the requesters and bridge.
interface mem_bus_arbiter_if;
    logic        cpu_req;
    logic        dma_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [2:0]  cpu_write_size;
    logic [2:0]  cpu_read_size;
    logic [2:0]  dma_write_size;
    logic [2:0]  dma_read_size;
    logic [31:0] cpu_rdata;
    logic [31:0] dma_rdata;
    logic        cpu_done;
    logic        dma_done;
    logic        cpu_err;
    logic        dma_err;
    logic        cpu_stall;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [2:0]  bus_write_size;
    logic [2:0]  bus_read_size;
    logic [31:0] bus_read_data;
    logic        bus_ready;

    modport master (
        input  cpu_req, dma_req, cpu_addr, cpu_wdata, dma_addr, dma_wdata,
               cpu_write_size, cpu_read_size, dma_write_size, dma_read_size,
               bus_read_data, bus_ready,
        output cpu_rdata, dma_rdata, cpu_done, dma_done, cpu_err, dma_err, cpu_stall,
               bus_address, bus_write_data, bus_write_size, bus_read_size
    );

    modport slave (
        output cpu_req, dma_req, cpu_addr, cpu_wdata, dma_addr, dma_wdata,
               cpu_write_size, cpu_read_size, dma_write_size, dma_read_size,
               bus_read_data, bus_ready,
        input  cpu_rdata, dma_rdata, cpu_done, dma_done, cpu_err, dma_err, cpu_stall,
               bus_address, bus_write_data, bus_write_size, bus_read_size
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single memory bus bridge: round-robin on ties,
// one transfer at a time, with a bounded wait for bus_ready that ends in an error response.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      r_state;
    logic        r_lastDma;
    logic        r_grantDma;
    logic [7:0]  r_waitCnt;
    logic [31:0] r_busAddr;
    logic [31:0] r_busWdata;
    logic [2:0]  r_busWsize;
    logic [2:0]  r_busRsize;
    logic [31:0] r_cpuRdata;
    logic [31:0] r_dmaRdata;
    logic        r_cpuDone;
    logic        r_dmaDone;
    logic        r_cpuErr;
    logic        r_dmaErr;

    logic        w_pickDma;
    logic [31:0] w_selAddr;
    logic [31:0] w_selWdata;
    logic [2:0]  w_selWsize;
    logic [2:0]  w_selRsize;
    logic        w_finish;
    logic [31:0] w_respData;

    // On a tie the requester that did not win the previous tie goes first.
    assign w_pickDma  = bus.dma_req & (~bus.cpu_req | ~r_lastDma);
    assign w_selAddr  = w_pickDma ? bus.dma_addr       : bus.cpu_addr;
    assign w_selWdata = w_pickDma ? bus.dma_wdata      : bus.cpu_wdata;
    assign w_selWsize = w_pickDma ? bus.dma_write_size : bus.cpu_write_size;
    // A request carrying both sizes is issued as a pure write.
    assign w_selRsize = (w_selWsize != 3'd0) ? 3'd0
                      : (w_pickDma ? bus.dma_read_size : bus.cpu_read_size);

    // bus_ready on the final counted cycle still completes normally.
    assign w_finish   = bus.bus_ready | (r_waitCnt == TIMEOUT_CNT);
    assign w_respData = bus.bus_ready ? bus.bus_read_data : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_lastDma  <= 1'b1;
            r_grantDma <= 1'b0;
            r_waitCnt  <= 8'd0;
            r_busAddr  <= 32'h0;
            r_busWdata <= 32'h0;
            r_busWsize <= 3'd0;
            r_busRsize <= 3'd0;
            r_cpuRdata <= 32'h0;
            r_dmaRdata <= 32'h0;
            r_cpuDone  <= 1'b0;
            r_dmaDone  <= 1'b0;
            r_cpuErr   <= 1'b0;
            r_dmaErr   <= 1'b0;
        end else begin
            r_cpuDone <= 1'b0;
            r_dmaDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req | bus.dma_req) begin
                        r_state    <= XFER;
                        r_grantDma <= w_pickDma;
                        r_waitCnt  <= 8'd0;
                        r_busAddr  <= w_selAddr;
                        r_busWdata <= w_selWdata;
                        r_busWsize <= w_selWsize;
                        r_busRsize <= w_selRsize;
                        if (bus.cpu_req & bus.dma_req) begin
                            r_lastDma <= w_pickDma;
                        end
                    end
                end
                XFER: begin
                    if (w_finish) begin
                        r_state    <= RESP;
                        r_busWsize <= 3'd0;
                        r_busRsize <= 3'd0;
                        if (r_grantDma) begin
                            r_dmaRdata <= w_respData;
                            r_dmaErr   <= ~bus.bus_ready;
                            r_dmaDone  <= 1'b1;
                        end else begin
                            r_cpuRdata <= w_respData;
                            r_cpuErr   <= ~bus.bus_ready;
                            r_cpuDone  <= 1'b1;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bus_address    = r_busAddr;
    assign bus.bus_write_data = r_busWdata;
    assign bus.bus_write_size = r_busWsize;
    assign bus.bus_read_size  = r_busRsize;
    assign bus.cpu_rdata      = r_cpuRdata;
    assign bus.dma_rdata      = r_dmaRdata;
    assign bus.cpu_done       = r_cpuDone;
    assign bus.dma_done       = r_dmaDone;
    assign bus.cpu_err        = r_cpuErr;
    assign bus.dma_err        = r_dmaErr;
    assign bus.cpu_stall      = bus.cpu_req & ~r_cpuDone;
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of XFER cycles to wait for bus_ready before aborting (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req / dma_req  input  1 each  access request from the pipeline MEM stage / DMA; held high until the matching done pulse.
REQ-005 cpu_addr, cpu_wdata / dma_addr, dma_wdata  input  32 each  byte address and store data.
REQ-006 cpu_write_size, cpu_read_size / dma_write_size, dma_read_size  input  3 each  access size, using the codebase encoding (0 = none).
REQ-007 cpu_rdata, dma_rdata  output  32 each  load result; valid while the matching done is high.
REQ-008 cpu_done, dma_done  output  1 each  one-cycle completion pulses.
REQ-009 cpu_err, dma_err  output  1 each  timeout flag; valid only with the matching done.
REQ-010 cpu_stall  output  1  equals cpu_req & ~cpu_done (combinational); freezes the pipeline.
REQ-011 bus_address, bus_write_data  output  32 each  driven to the bridge.
REQ-012 bus_write_size, bus_read_size  output  3 each  driven to the bridge.
REQ-013 bus_read_data  input  32  bridge load data.
REQ-014 bus_ready  input  1  bridge completion; sampled only in XFER.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, XFER and RESP.
REQ-016 IDLE, no request pending: stay in IDLE; bus sizes = 0.
REQ-017 IDLE, exactly one request pending: at the next edge, grant that requester, latch its addr, wdata and sizes into the bus registers, then enter XFER.
REQ-018 IDLE, both requests pending: grant the requester not recorded in last_grant (round-robin); update last_grant to the winner.
REQ-019 If a latched request has both sizes nonzero, the write SHALL take effect and bus_read_size SHALL be forced to 0.
REQ-020 XFER: bus outputs SHALL hold the latched values, stable for the whole transfer, regardless of requester input changes.
REQ-021 XFER, bus_ready=1: at the next edge, capture bus_read_data into the winner's rdata register, err=0, enter RESP.
REQ-022 XFER: an 8-bit wait counter SHALL clear on entry and increment each XFER cycle with bus_ready=0.
REQ-023 Timeout: when the counter reaches TIMEOUT with bus_ready=0, at the next edge set rdata=32'h0, err=1 and enter RESP.
REQ-024 bus_ready in the same cycle the count reaches TIMEOUT SHALL win; no error is flagged.
REQ-025 RESP: assert only the winner's done for exactly one cycle, drive bus sizes = 0, accept no new grant, and go to IDLE at the next edge.
REQ-026 Minimum latency: request sampled at edge k; bus driven from edge k+1; with bus_ready=1 in that cycle, done is high in cycle k+2; re-grant no earlier than edge k+3.
REQ-027 Each rdata register SHALL hold its value until that requester's next completion.
REQ-028 Dropping a request during XFER SHALL NOT abort the transfer; it completes and the done pulse is still issued.
REQ-029 bus_ready outside XFER SHALL be ignored.

Reset
REQ-030 On reset assertion, all outputs and state SHALL clear immediately (asynchronously): state=IDLE, last_grant=DMA (so the CPU wins the first tie), counter=0, bus outputs=0, rdata=0, done=0, err=0.
REQ-031 Reset during XFER or RESP SHALL abandon the transfer without any done pulse; after release, the first edge SHALL behave as IDLE.

Verification
REQ-032 cpu word read of 0x0000_3000, bus_ready=1 in the first XFER cycle, bus_read_data=0x1234_5678 -> cpu_done high in cycle k+2, cpu_rdata=0x1234_5678, cpu_err=0, cpu_stall low in that cycle.
REQ-033 cpu_req and dma_req both rise together after reset -> CPU granted first; DMA granted at edge k+3; a second simultaneous pair of requests -> DMA granted first.
REQ-034 DMA write with bus_ready held 0, TIMEOUT=15 -> dma_done with dma_err=1 and dma_rdata=0 after 16 XFER cycles; bus sizes=0 in RESP.
REQ-035 bus_ready rises exactly when the counter reaches 15 -> normal completion, err=0.
REQ-036 Assert reset during XFER of a CPU read -> bus sizes=0 immediately, no cpu_done pulse; cpu_req still high after release -> a fresh grant at the first edge.
REQ-037 cpu_addr changes during a 3-cycle wait -> bus_address stays at the value latched at grant for all 3 cycles.
